seq_divider: RTL and testbench

//  Sequential unsigned restoring divider, one quotient bit per clock; the inverse of the

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encodings and counter sizing.
package seq_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int cnt_width(input int n_steps);
        return $clog2(n_steps + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   r_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   r_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] diff;

    always_comb begin
        shifted = {r_i[DIVISOR_W-1:0], bit_i};
        // Extra top bit acts as the borrow: set means the trial went negative.
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        q_o     = ~diff[DIVISOR_W+1];
        r_o     = q_o ? diff[DIVISOR_W:0] : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional SEQ_DIVIDER_ZERO_DETECT_EN: divide-by-zero short-cuts straight to DONE and flags div_zero_o.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | one restoring step per edge, dividend MSB first
// DONE  | done_o pulse; results valid; start_i may begin the next division
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o,
    output logic [DIVISOR_W-1:0]  remainder_o,
    output logic                  div_zero_o
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    logic [1:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [DIVISOR_W:0]    r_q,         r_d;
    logic [DIVIDEND_W-1:0] dvd_q,       dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q,       dsr_d;
    logic [DIVIDEND_W-1:0] quo_q,       quo_d;
    logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dz_q,        dz_d;

    logic [DIVISOR_W:0]    step_r;
    logic                  step_q;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .r_i       (r_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dsr_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    state_d = ST_RUN;
                    dvd_d   = dividend_i;
                    dsr_d   = divisor_i;
                    r_d     = '0;
                    cnt_d   = '0;
                    quo_d   = '0;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
                    if (divisor_i == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend_i[DIVISOR_W-1:0];
                        dz_d        = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                r_d   = step_r;
                dvd_d = dvd_q << 1;
                quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d     = ST_DONE;
                    quotient_d  = {quo_q[DIVIDEND_W-2:0], step_q};
                    remainder_d = step_r[DIVISOR_W-1:0];
                    dz_d        = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    assign div_zero_o  = dz_q;
`else
    // Without zero detection the flag register still exists but never sets.
    assign div_zero_o  = 1'b0 & dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider; expectations follow SEQ_DIVIDER_ZERO_DETECT_EN.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    localparam int ZD_LAT = 1;
    localparam int ZD_FLG = 1;
`else
    localparam int ZD_LAT = 9;
    localparam int ZD_FLG = 0;
`endif

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div_zero_o  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle cyc0; returns the cycle in which done is seen, or -1.
    task automatic wait_done(input int cyc0, output int lat);
        int cyc = cyc0;
        while (cyc <= 40 && done !== 1'b1) begin
            tick();
            cyc++;
        end
        lat = (done === 1'b1) ? cyc : -1;
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input int exp_q, input int exp_r, input int exp_dz,
                           input int exp_lat, input bit chk_busy);
        int cyc;
        int lat;
        bit busy_ok;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        lat      = -1;
        busy_ok  = 1'b1;
        while (cyc <= 20) begin
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, int'(quotient), exp_q);
        chk({tag, "_r"}, int'(remainder), exp_r);
        chk({tag, "_dz"}, int'(div_zero), exp_dz);
        if (chk_busy) begin
            chk({tag, "_busy_run"}, int'(busy_ok), 1);
            chk({tag, "_busy_done"}, int'(busy), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int a, b, eq, er, el;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dz", int'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_div("d200_7", 8'd200, 4'd7, 28, 4, 0, 9, 1'b1);
        run_div("d255_1", 8'd255, 4'd1, 255, 0, 0, 9, 1'b1);
        run_div("d5_9", 8'd5, 4'd9, 0, 5, 0, 9, 1'b1);
        run_div("d15_15", 8'd15, 4'd15, 1, 0, 0, 9, 1'b1);
        run_div("d100_0", 8'd100, 4'd0, 255, 4, ZD_FLG, ZD_LAT, 1'b0);
        run_div("d9_2", 8'd9, 4'd2, 4, 1, 0, 9, 1'b1);

        // start pulse mid-run with new operands must be ignored
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        dividend = 8'd15;
        divisor  = 4'd15;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, lat);
        chk("ign_lat", lat, 9);
        chk("ign_q", int'(quotient), 28);
        chk("ign_r", int'(remainder), 4);
        tick();
        chk("ign_idle_busy", int'(busy), 0);

        // start held across DONE: second division begins with no idle cycle
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        tick();
        wait_done(1, lat);
        chk("b2b_lat1", lat, 9);
        chk("b2b_q1", int'(quotient), 28);
        chk("b2b_r1", int'(remainder), 4);
        dividend = 8'd255;
        divisor  = 4'd1;
        tick();
        start = 1'b0;
        chk("b2b_nogap_busy", int'(busy), 1);
        chk("b2b_nogap_done", int'(done), 0);
        wait_done(10, lat);
        chk("b2b_lat2", lat, 18);
        chk("b2b_q2", int'(quotient), 255);
        chk("b2b_r2", int'(remainder), 0);
        tick();

        // reset in cycle 4 of a run clears everything at once
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_q", int'(quotient), 0);
        chk("mrst_r", int'(remainder), 0);
        chk("mrst_dz", int'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_div("post_rst", 8'd200, 4'd7, 28, 4, 0, 9, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            if (b == 0) begin
                eq = 255;
                er = a % 16;
                el = ZD_LAT;
            end else begin
                eq = a / b;
                er = a % b;
                el = 9;
            end
            run_div("rnd", 8'(a), 4'(b), eq, er, (b == 0) ? ZD_FLG : 0, el, 1'b0);
            if (b != 0) begin
                chk("rnd_inv", int'(quotient) * b + int'(remainder), a);
                chk("rnd_rlt", int'(int'(remainder) < b), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
